pc_sequencer: RTL
=================

# pc_sequencer

Controller that owns and sequences the fetch program counter of the pipeline. Every cycle it picks the next PC from:
- sequential fall-through
- branch redirect from EX
- jump redirect from ID
- optional exception vector

It also honours hazard stalls, issues pipeline flushes on redirects and counts stall cycles. It replaces the bare PC register in front of instruction memory and sits between the hazard unit, the ID/EX redirect sources and the IF stage.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset and held through the boot cycle
- EXC_VECTOR, 32'h0000_0080, exception entry address; used only when PC_SEQ_EXC_EN is defined
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit request to hold PC
- branch_taken  in  1  EX-stage branch resolved taken
- branch_target  in  32  branch destination
- jump  in  1  ID-stage jump decoded
- jump_target  in  32  jump destination
- exc  in  1  exception request; present only with PC_SEQ_EXC_EN
- pc  out  32  current fetch address to instruction memory
- pc_plus4  out  32  pc + 4, combinational from pc
- fetch_valid  out  1  fetch address is valid this cycle
- flush  out  1  squash IF/ID (and ID/EX for branch or exception)
- redirect_cause  out  2  00 none, 01 jump, 10 branch, 11 exception; qualifies flush
- align_err  out  1  one-cycle pulse when a redirect target had nonzero bits [1:0]
- stall_cnt  out  8  consecutive stall cycles, saturating

## Operation
- States: BOOT, RUN, HOLD. Reset forces BOOT.
- BOOT:
  - pc = RESET_VECTOR, fetch_valid = 0.
  - Redirect inputs arriving in BOOT are latched into a one-entry pending register (target plus cause).
  - Next state is RUN.
- RUN and HOLD, priority: exception > branch > jump > stall > sequential.
  - Branch beats jump because the EX instruction is older.
  - Redirect: pc <= target with bits [1:0] forced to 00. flush = 1 and redirect_cause is set in the same cycle as the accepted request. Next state is RUN.
  - A redirect overrides stall, since the stalled instructions are squashed.
  - Stall with no redirect: pc holds, next state is HOLD, stall_cnt increments and saturates at 255.
  - No stall and no redirect: pc <= pc + 4, with 32-bit wrap (32'hFFFF_FFFC goes to 0). Next state is RUN and stall_cnt clears.
- Pending redirect: applied on the first RUN cycle, with priority above the live inputs of that cycle. The live inputs of that cycle are ignored, because that instruction is flushed.
- align_err pulses for the accepted redirect only.

## Timing
- Reset values: pc = RESET_VECTOR, fetch_valid = 0, flush = 0, redirect_cause = 00, align_err = 0, stall_cnt = 0, state = BOOT.
- Reset is asynchronous. Asserting it mid-redirect or mid-stall discards the pending register and the stall count immediately.
- First rising edge after reset deasserts: pc stays RESET_VECTOR, fetch_valid goes 1.
- Second edge: pc advances.
- Redirect latency: a request sampled at edge N makes pc = target after edge N.
- flush and redirect_cause are combinational from the inputs and the pending register, valid during the request cycle.
- stall_cnt and align_err are registered and update at the same edge as pc.
- Stall is level-sensitive; holding it for k cycles gives stall_cnt = min(k, 255).

## Configuration
- PC_SEQ_EXC_EN defined:
  - exc port and EXC_VECTOR exist.
  - Exception has top priority, flush with cause 11.
- PC_SEQ_EXC_EN undefined:
  - No exc port.
  - Cause 11 is never produced.
  - The priority chain starts at branch.

## Structure
- Shared package pc_seq_pkg:
  - state enum (BOOT, RUN, HOLD)
  - redirect cause encodings
  - default RESET_VECTOR and EXC_VECTOR constants
  - stall counter width
- Sub-module pc_next_sel:
  - Purely combinational priority selector.
  - Outputs next pc, cause, flush and align flag.
  - The sequencer holds state, pc register, pending register and stall counter.

## Test plan
- Reset, then 4 free-running edges -> pc 0, 0, 4, 8, 12; fetch_valid 0 then 1.
- At pc = 16, branch_taken = 1 with target 32'h40 and jump = 1 with target 32'h80 in the same cycle -> flush = 1, cause 10, next pc = 32'h40.
- stall high for 300 cycles at pc = 8 -> pc holds 8, stall_cnt saturates at 255; stall low -> pc = 12, stall_cnt = 0.
- stall and jump to 32'h23 in the same cycle -> pc = 32'h20, cause 01, align_err pulses once.
- jump to 32'h100 during BOOT -> pending latched; first RUN cycle pc = 32'h100 with flush.
- With PC_SEQ_EXC_EN, exc and branch together -> pc = 32'h80, cause 11.
- Reset asserted mid-stall -> pc = RESET_VECTOR and stall_cnt = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the fetch PC sequencer.
//   state_e      : sequencer states BOOT / RUN / HOLD
//   cause_e      : redirect cause encoding driven on redirect_cause
//   RESET_VECTOR : PC loaded by reset and held through the boot cycle
//   EXC_VECTOR   : exception entry address (used when PC_SEQ_EXC_EN is defined)
//   STALL_CNT_W  : width of the saturating stall counter
package pc_seq_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'b00,
      CAUSE_JUMP   = 2'b01,
      CAUSE_BRANCH = 2'b10,
      CAUSE_EXC    = 2'b11
   } cause_e;

   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR   = 32'h0000_0080;
   localparam int          STALL_CNT_W  = 8;

   // Redirect targets are word aligned by dropping the two low bits.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational priority selector for the next fetch PC.
//   Optional feature macro: PC_SEQ_EXC_EN (adds the exc input, top priority).
//   Ports:
//     pc            in  32  current fetch PC
//     stall         in  1   hazard hold request
//     branch_taken  in  1   EX branch resolved taken
//     branch_target in  32  branch destination
//     jump          in  1   ID jump decoded
//     jump_target   in  32  jump destination
//     exc           in  1   exception request (PC_SEQ_EXC_EN only)
//     pend_cause    in  2   cause of a redirect latched during boot (NONE if empty)
//     pend_tgt      in  32  target of the latched redirect
//     cause         out 2   selected redirect cause
//     tgt           out 32  raw (unaligned) selected target
//     nxt_pc        out 32  next PC: aligned target, held PC, or PC + 4
//     flush         out 1   a redirect was selected
//     align         out 1   the selected target had nonzero bits [1:0]
module pc_next_sel
   import pc_seq_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
`ifdef PC_SEQ_EXC_EN
   input  logic        exc,
`endif
   input  cause_e      pend_cause,
   input  logic [31:0] pend_tgt,
   output cause_e      cause,
   output logic [31:0] tgt,
   output logic [31:0] nxt_pc,
   output logic        flush,
   output logic        align
);

   // A pending boot-time redirect outranks every live request because the
   // instruction presenting those live requests is itself being squashed.
   always_comb begin
      cause = CAUSE_NONE;
      tgt   = pc;
      if (pend_cause != CAUSE_NONE) begin
         cause = pend_cause;
         tgt   = pend_tgt;
      end
`ifdef PC_SEQ_EXC_EN
      else if (exc) begin
         cause = CAUSE_EXC;
         tgt   = EXC_VECTOR;
      end
`endif
      else if (branch_taken) begin
         cause = CAUSE_BRANCH;
         tgt   = branch_target;
      end
      else if (jump) begin
         cause = CAUSE_JUMP;
         tgt   = jump_target;
      end
      flush  = cause != CAUSE_NONE;
      align  = flush && (tgt[1:0] != 2'b00);
      nxt_pc = flush ? word_align(tgt) : stall ? pc : pc + 32'd4;
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns and sequences the fetch program counter.
//   Optional feature macro: PC_SEQ_EXC_EN (exception input, vector EXC_VECTOR, cause 11).
//   Ports:
//     clk            in  1   clock, rising edge
//     reset          in  1   asynchronous active-high reset
//     stall          in  1   hazard unit hold request
//     branch_taken   in  1   EX branch resolved taken
//     branch_target  in  32  branch destination
//     jump           in  1   ID jump decoded
//     jump_target    in  32  jump destination
//     exc            in  1   exception request (PC_SEQ_EXC_EN only)
//     pc             out 32  current fetch address
//     pc_plus4       out 32  pc + 4
//     fetch_valid    out 1   fetch address valid (low during boot)
//     flush          out 1   squash younger stages, same cycle as accepted redirect
//     redirect_cause out 2   00 none, 01 jump, 10 branch, 11 exception
//     align_err      out 1   registered pulse: accepted target was misaligned
//     stall_cnt      out 8   consecutive stall cycles, saturating
module pc_sequencer
   import pc_seq_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [31:0]            branch_target,
   input  logic                   jump,
   input  logic [31:0]            jump_target,
`ifdef PC_SEQ_EXC_EN
   input  logic                   exc,
`endif
   output logic [31:0]            pc,
   output logic [31:0]            pc_plus4,
   output logic                   fetch_valid,
   output logic                   flush,
   output logic [1:0]             redirect_cause,
   output logic                   align_err,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   state_e                 state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [31:0]            pend_tgt_q, pend_tgt_d;
   cause_e                 pend_cause_q, pend_cause_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   align_err_q, align_err_d;
   cause_e                 sel_cause;
   logic [31:0]            sel_tgt, sel_pc;
   logic                   sel_flush, sel_align;
   logic                   boot;

   assign boot = state_q == BOOT;

   pc_next_sel u_sel (
      .pc            (pc_q),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
`ifdef PC_SEQ_EXC_EN
      .exc           (exc),
`endif
      .pend_cause    (pend_cause_q),
      .pend_tgt      (pend_tgt_q),
      .cause         (sel_cause),
      .tgt           (sel_tgt),
      .nxt_pc        (sel_pc),
      .flush         (sel_flush),
      .align         (sel_align)
   );

   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= BOOT;
      else       state_q <= state_d;

   always_comb begin
      state_d = (!boot && !sel_flush && stall) ? HOLD : RUN;
   end

   // Nothing is accepted during boot; requests there only fill the pending slot.
   always_comb begin
      fetch_valid    = !boot;
      flush          = !boot && sel_flush;
      redirect_cause = boot ? CAUSE_NONE : sel_cause;
   end

   // The pending slot is written only on the boot cycle and emptied on the
   // following cycle, which is the one that applies it.
   always_comb begin
      pc_d         = boot ? RESET_VECTOR : sel_pc;
      pend_cause_d = boot ? sel_cause : CAUSE_NONE;
      pend_tgt_d   = boot ? sel_tgt : pend_tgt_q;
      align_err_d  = !boot && sel_align;
      stall_cnt_d  = (boot || sel_flush || !stall) ? '0 :
                     (stall_cnt_q == {STALL_CNT_W{1'b1}}) ? stall_cnt_q : stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc_q         <= RESET_VECTOR;
         pend_cause_q <= CAUSE_NONE;
         pend_tgt_q   <= '0;
         stall_cnt_q  <= '0;
         align_err_q  <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         pend_cause_q <= pend_cause_d;
         pend_tgt_q   <= pend_tgt_d;
         stall_cnt_q  <= stall_cnt_d;
         align_err_q  <= align_err_d;
      end

   assign pc        = pc_q;
   assign pc_plus4  = pc_q + 32'd4;
   assign stall_cnt = stall_cnt_q;
   assign align_err = align_err_q;

endmodule
